branch_predictor_gshare: RTL
============================

Name: branch_predictor_gshare

Overview:
- Parametrised successor to the single-counter branch predictor.
- Holds a PC-indexed table of saturating counters, with optional gshare global-history hashing, speculative history update and mispredict recovery.
- Lookup happens in ID (combinational prediction). Update happens when the branch resolves in EX.
- Also provides saturating performance counters for lookups and mispredicts.

Parameters:
- ENTRIES, 64: number of table counters. Power of two, >=2. IDX_W = log2(ENTRIES).
- CTR_W, 2: counter width, 1..4. Prediction is the counter MSB.
- HIST_W, 6: global history length, 0..IDX_W. 0 selects pure bimodal mode.
- PC_LSB, 2: lowest PC bit used for indexing.
- INIT_CTR, 2: reset value of every table counter, must be < 2^CTR_W.
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- lookup_i  in  1  branch in ID is consuming a prediction this cycle
- lookup_pc_i  in  32  PC of the instruction in ID
- predict_o  out  1  predicted taken, combinational from lookup_pc_i and the GHR
- lookup_idx_o  out  IDX_W  table index used; carried down the pipeline
- lookup_ghr_o  out  max(HIST_W,1)  GHR value before this lookup's speculative shift
- update_i  in  1  branch resolved in EX this cycle
- update_idx_i  in  IDX_W  index captured at lookup
- update_taken_i  in  1  actual outcome
- update_mispredict_i  in  1  prediction was wrong
- update_ghr_i  in  max(HIST_W,1)  GHR snapshot captured at lookup
- lookup_cnt_o  out  CNT_W  number of lookups
- mispredict_cnt_o  out  CNT_W  number of mispredicts

Behaviour:
- Reset (async, immediate on rst_i=1, no clock edge needed):
  - all table counters = INIT_CTR
  - GHR = 0
  - lookup_cnt_o = mispredict_cnt_o = 0
  - predict_o = INIT_CTR[CTR_W-1] for any PC
- Index:
  - lookup_idx_o = lookup_pc_i[PC_LSB+IDX_W-1:PC_LSB] XOR zero-extended GHR[HIST_W-1:0].
  - With HIST_W=0 there is no XOR and lookup_ghr_o is tied to 0.
- Prediction:
  - predict_o = counter[lookup_idx_o][CTR_W-1].
  - Zero latency (combinational); it does not depend on lookup_i.
- Counter update, on a clock edge with update_i=1:
  - taken: counter[update_idx_i] increments, saturating at 2^CTR_W-1.
  - not taken: counter[update_idx_i] decrements, saturating at 0.
  - The new value is visible to lookups from the next cycle.
  - No bypass: a same-cycle lookup of the same index sees the old value.
- GHR, when HIST_W>0, in priority order:
  - update_i & update_mispredict_i: GHR <= {update_ghr_i[HIST_W-2:0], update_taken_i}. A same-cycle lookup is on the wrong path and does not shift the GHR.
  - else lookup_i: GHR <= {GHR[HIST_W-2:0], predict_o} (speculative).
  - else GHR holds.
  - With HIST_W=1 the shift degenerates to GHR <= new bit.
  - A correctly predicted update leaves the GHR untouched.
- Performance counters:
  - lookup_cnt_o increments on every cycle with lookup_i=1, including squashed lookups.
  - mispredict_cnt_o increments on update_i & update_mispredict_i.
  - Both saturate at all-ones and never wrap.
- Simultaneous lookup_i and update_i: both take effect (table write and counter increments); only the GHR follows the priority above.
- update_mispredict_i with update_i=0 is ignored.
- Elaboration-time error if ENTRIES is not a power of two, HIST_W > IDX_W, or INIT_CTR >= 2^CTR_W.

Decomposition:
- Package bp_pkg holds:
  - the sat_inc/sat_dec functions
  - the counter-state constants STRONG_NT=0 and WEAK_T=2^(CTR_W-1)
  - the default parameter values
- One natural sub-module, sat_counter:
  - Parametrised width, async reset value, inc/dec enables.
  - Instantiated ENTRIES times for the table and twice for the performance counters.

Test Plan:
- Reset with defaults, any lookup_pc_i -> predict_o=1, both counters 0, lookup_ghr_o=0.
- Bimodal saturation (HIST_W=0):
  - At PC 0x40, update not-taken 4x -> counter 0 (saturated), predict_o=0; PC 0x44 still predicts 1.
  - Then update taken 2x at PC 0x40 -> counter 2, predict_o=1.
- Aliasing (HIST_W=0, ENTRIES=64): updating PC 0x40 not-taken 2x -> PC 0x140 also predicts 0 (both index 16).
- Speculative history (HIST_W=6): three consecutive lookups predicting taken -> GHR 0b000111; the next lookup at PC 0x40 gives lookup_idx_o = 16^7 = 23.
- Mispredict recovery with same-cycle lookup:
  - Stimulus: update_i=1, update_mispredict_i=1, update_ghr_i=0b000101, update_taken_i=0, lookup_i=1.
  - Response: GHR becomes 0b001010; mispredict_cnt_o +1 and lookup_cnt_o +1.
- Async reset mid-operation: after several updates, pulse rst_i between clock edges -> counters, GHR and performance counters cleared immediately; predict_o=1.

Source files
------------

// File: rtl/branch_predictor_gshare_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_pkg : shared constants, defaults and saturating helpers for the predictor
// Revision: 1.0
// ---------------------------------------------------------------------------
package bp_pkg;

  localparam int DEF_ENTRIES  = 64;
  localparam int DEF_CTR_W    = 2;
  localparam int DEF_HIST_W   = 6;
  localparam int DEF_PC_LSB   = 2;
  localparam int DEF_INIT_CTR = 2;
  localparam int DEF_CNT_W    = 32;

  localparam int STRONG_NT = 0;
  localparam int WEAK_T    = 1 << (DEF_CTR_W - 1);

  // Values are carried at 64 bits so one helper serves every counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v >= max) ? v : v + 64'd1;
  endfunction

  function automatic logic [63:0] sat_dec(input logic [63:0] v);
    return (v == 64'd0) ? v : v - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_gshare_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : W-bit up/down counter saturating at 0 and all-ones
// Revision: 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W       = 2,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);
  import bp_pkg::*;

  localparam logic [63:0] MAX = {64{1'b1}} >> (64 - W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= W'(RST_VAL);
    end else if (inc) begin
      value <= W'(sat_inc(64'(value), MAX));
    end else if (dec) begin
      value <= W'(sat_dec(64'(value)));
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predictor_gshare : PC/GHR-indexed saturating-counter branch predictor
// Revision: 1.0
// ---------------------------------------------------------------------------
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter  int ENTRIES  = DEF_ENTRIES,
  parameter  int CTR_W    = DEF_CTR_W,
  parameter  int HIST_W   = DEF_HIST_W,
  parameter  int PC_LSB   = DEF_PC_LSB,
  parameter  int INIT_CTR = DEF_INIT_CTR,
  parameter  int CNT_W    = DEF_CNT_W,
  localparam int IDX_W    = $clog2(ENTRIES),
  localparam int GHR_W    = (HIST_W > 0) ? HIST_W : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lookup_i,
  input  logic [31:0]      lookup_pc_i,
  output logic             predict_o,
  output logic [IDX_W-1:0] lookup_idx_o,
  output logic [GHR_W-1:0] lookup_ghr_o,
  input  logic             update_i,
  input  logic [IDX_W-1:0] update_idx_i,
  input  logic             update_taken_i,
  input  logic             update_mispredict_i,
  input  logic [GHR_W-1:0] update_ghr_i,
  output logic [CNT_W-1:0] lookup_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_err_entries
    $error("ENTRIES must be a power of two >= 2");
  end
  if (HIST_W > IDX_W) begin : g_err_hist
    $error("HIST_W must not exceed log2(ENTRIES)");
  end
  if (INIT_CTR >= (1 << CTR_W)) begin : g_err_init
    $error("INIT_CTR must fit in CTR_W bits");
  end

  logic [CTR_W-1:0] ctr_tbl [ENTRIES];
  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] idx;
  logic             predict;
  logic             recover;
  logic             unused_pc;

  assign pc_idx    = lookup_pc_i[PC_LSB +: IDX_W];
  assign unused_pc = ^lookup_pc_i;
  assign recover   = update_i & update_mispredict_i;

  if (HIST_W > 0) begin : g_gshare
    logic [GHR_W-1:0] base;
    logic [GHR_W-1:0] shifted;
    logic             new_bit;

    assign idx = pc_idx ^ IDX_W'(ghr);

    // A recovery restarts history from the branch's own snapshot; a same-cycle
    // lookup is on the squashed path and must not contribute its bit.
    assign base    = recover ? update_ghr_i : ghr;
    assign new_bit = recover ? update_taken_i : predict;

    if (HIST_W == 1) begin : g_hist1
      assign shifted = new_bit;
    end else begin : g_histn
      assign shifted = {base[GHR_W-2:0], new_bit};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        ghr <= '0;
      end else if (recover || lookup_i) begin
        ghr <= shifted;
      end
    end
  end else begin : g_bimodal
    logic unused_hist;
    assign idx         = pc_idx;
    assign ghr         = '0;
    assign unused_hist = ^update_ghr_i;
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_table
    logic hit;
    assign hit = update_i && (update_idx_i == IDX_W'(i));

    sat_counter #(
      .W       (CTR_W),
      .RST_VAL (INIT_CTR)
    ) u_ctr (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (hit & update_taken_i),
      .dec   (hit & ~update_taken_i),
      .value (ctr_tbl[i])
    );
  end

  assign predict      = ctr_tbl[idx][CTR_W-1];
  assign predict_o    = predict;
  assign lookup_idx_o = idx;
  assign lookup_ghr_o = ghr;

  sat_counter #(
    .W       (CNT_W),
    .RST_VAL (0)
  ) u_lookup_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (lookup_i),
    .dec   (1'b0),
    .value (lookup_cnt_o)
  );

  sat_counter #(
    .W       (CNT_W),
    .RST_VAL (0)
  ) u_mispredict_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (recover),
    .dec   (1'b0),
    .value (mispredict_cnt_o)
  );

endmodule
`default_nettype wire
